// File: rtl/shift_add_accum_if.sv
// Handshake bundle between the upstream shifter, the shift-add accumulator
// and the downstream color stage.
interface shift_add_accum_if #(
    parameter int COLOR_W = 8,
    parameter int SHIFT_W = 10
);
    logic [SHIFT_W-1:0] term_in;
    logic               term_sub;
    logic               term_last;
    logic               in_valid;
    logic               in_ready;
    logic [COLOR_W-1:0] color_out;
    logic               out_valid;
    logic               out_ready;
    logic               sat_flag;
    logic               term_ovf;

    // Upstream/downstream side: drives terms, consumes results.
    modport master (
        output term_in, term_sub, term_last, in_valid, out_ready,
        input  in_ready, color_out, out_valid, sat_flag, term_ovf
    );

    // Accumulator side.
    modport slave (
        input  term_in, term_sub, term_last, in_valid, out_ready,
        output in_ready, color_out, out_valid, sat_flag, term_ovf
    );
endinterface

// File: rtl/shift_add_accum.sv
// Shift-add accumulator: sums up to MAX_TERMS signed shifted terms per pixel
// and emits the result clamped to the unsigned COLOR_W range.
module shift_add_accum #(
    parameter int COLOR_W   = 8,
    parameter int SHIFT_W   = 10,
    parameter int MAX_TERMS = 4,
    parameter int ACC_W     = 13
) (
    input  logic              clk,
    input  logic              rst,
    shift_add_accum_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0]        CNT_MAX   = CNT_W'(MAX_TERMS);
    localparam logic signed [ACC_W-1:0] COLOR_MAX = ACC_W'((1 << COLOR_W) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic signed [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]          term_cnt, cnt_nxt;
    logic [COLOR_W-1:0]        color_q, color_nxt;
    logic                      sat_q, sat_nxt;
    logic                      ovf_q, ovf_nxt;

    logic                      accept;
    logic signed [ACC_W-1:0]   term_ext;
    logic signed [ACC_W-1:0]   acc_upd;
    logic [CNT_W-1:0]          cnt_upd;
    logic [COLOR_W-1:0]        clamp_color;
    logic                      clamp_sat;

    assign accept   = bus.in_valid && bus.in_ready;
    assign term_ext = signed'({{(ACC_W - SHIFT_W){1'b0}}, bus.term_in});

    // Candidate accumulator/count if the current term is accepted; a fresh
    // pixel starts from zero regardless of leftover state.
    always_comb begin
        acc_upd = (state == IDLE) ? '0 : acc;
        acc_upd = bus.term_sub ? (acc_upd - term_ext) : (acc_upd + term_ext);
        cnt_upd = (state == IDLE) ? CNT_W'(1) : (term_cnt + CNT_W'(1));
    end

    // Clamp the candidate sum to the unsigned color range.
    always_comb begin
        clamp_color = acc_upd[COLOR_W-1:0];
        clamp_sat   = 1'b0;
        if (acc_upd[ACC_W-1]) begin
            clamp_color = '0;
            clamp_sat   = 1'b1;
        end else if (acc_upd > COLOR_MAX) begin
            clamp_color = '1;
            clamp_sat   = 1'b1;
        end
    end

    // Next-state and next-register logic.
    // NOTE: every output of this block is given a default first so no path
    // leaves it unassigned -- that is what keeps latches from being inferred.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = term_cnt;
        color_nxt = color_q;
        sat_nxt   = sat_q;
        ovf_nxt   = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_nxt = acc_upd;
                    cnt_nxt = cnt_upd;
                    if (bus.term_last || (cnt_upd == CNT_MAX)) begin
                        state_nxt = OUT;
                        color_nxt = clamp_color;
                        sat_nxt   = clamp_sat;
                        ovf_nxt   = !bus.term_last;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            term_cnt <= '0;
            color_q  <= '0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            term_cnt <= cnt_nxt;
            color_q  <= color_nxt;
            sat_q    <= sat_nxt;
            ovf_q    <= ovf_nxt;
        end
    end

    assign bus.in_ready  = (state != OUT);
    assign bus.out_valid = (state == OUT);
    assign bus.color_out = color_q;
    assign bus.sat_flag  = sat_q;
    assign bus.term_ovf  = ovf_q;

endmodule

// File: tb/tb_shift_add_accum.sv
// Self-checking bench for shift_add_accum: table of pixels plus hand-written
// stall, overflow, backpressure and reset sequences.
module tb_shift_add_accum;

    localparam int COLOR_W   = 8;
    localparam int SHIFT_W   = 10;
    localparam int MAX_TERMS = 4;
    localparam int ACC_W     = 13;

    logic clk;
    logic rst;

    shift_add_accum_if #(.COLOR_W(COLOR_W), .SHIFT_W(SHIFT_W)) bus ();

    shift_add_accum #(
        .COLOR_W  (COLOR_W),
        .SHIFT_W  (SHIFT_W),
        .MAX_TERMS(MAX_TERMS),
        .ACC_W    (ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int                 n;
        logic [SHIFT_W-1:0] term [4];
        logic [3:0]         sub;
        bit                 use_last;
        logic [COLOR_W-1:0] exp_color;
        logic               exp_sat;
        logic               exp_ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one term for exactly one edge; inputs are left idle afterwards.
    task automatic send_term(input logic [SHIFT_W-1:0] t, input logic sub, input logic last);
        bus.term_in   = t;
        bus.term_sub  = sub;
        bus.term_last = last;
        bus.in_valid  = 1'b1;
        check("in_ready_before_accept", bus.in_ready, 1);
        tick();
        bus.in_valid  = 1'b0;
        bus.term_last = 1'b0;
        bus.term_sub  = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [COLOR_W-1:0] c, input logic s, input logic o);
        check({name, "_out_valid"}, bus.out_valid, 1);
        check({name, "_color"}, bus.color_out, c);
        check({name, "_sat"}, bus.sat_flag, s);
        check({name, "_ovf"}, bus.term_ovf, o);
        check({name, "_in_ready_low"}, bus.in_ready, 0);
    endtask

    task automatic handshake(input string name);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, "_hs_out_valid"}, bus.out_valid, 0);
        check({name, "_hs_in_ready"}, bus.in_ready, 1);
        check({name, "_hs_ovf"}, bus.term_ovf, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3, '{10'd100, 10'd50, 10'd30, 10'd0},  4'b0100, 1'b1, 8'd120, 1'b0, 1'b0};
        vecs[1] = '{2, '{10'd1020, 10'd10, 10'd0, 10'd0},  4'b0000, 1'b1, 8'd255, 1'b1, 1'b0};
        vecs[2] = '{2, '{10'd20, 10'd40, 10'd0, 10'd0},    4'b0010, 1'b1, 8'd0,   1'b1, 1'b0};
        vecs[3] = '{4, '{10'd10, 10'd10, 10'd10, 10'd10},  4'b0000, 1'b0, 8'd40,  1'b0, 1'b1};
        vecs[4] = '{1, '{10'd255, 10'd0, 10'd0, 10'd0},    4'b0000, 1'b1, 8'd255, 1'b0, 1'b0};
        vecs[5] = '{1, '{10'd256, 10'd0, 10'd0, 10'd0},    4'b0000, 1'b1, 8'd255, 1'b1, 1'b0};
        vecs[6] = '{1, '{10'd0, 10'd0, 10'd0, 10'd0},      4'b0000, 1'b1, 8'd0,   1'b0, 1'b0};
        vecs[7] = '{4, '{10'd1023, 10'd1023, 10'd1023, 10'd1023}, 4'b0000, 1'b1, 8'd255, 1'b1, 1'b0};
        vecs[8] = '{4, '{10'd1023, 10'd1023, 10'd1023, 10'd1023}, 4'b1111, 1'b0, 8'd0,   1'b1, 1'b1};

        rst           = 1'b1;
        bus.term_in   = '0;
        bus.term_sub  = 1'b0;
        bus.term_last = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_color", bus.color_out, 0);
        check("rst_sat", bus.sat_flag, 0);
        check("rst_ovf", bus.term_ovf, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Table of back-to-back pixels.
        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < vecs[v].n; i++)
                send_term(vecs[v].term[i], vecs[v].sub[i],
                          vecs[v].use_last && (i == vecs[v].n - 1));
            check_out($sformatf("vec%0d", v), vecs[v].exp_color, vecs[v].exp_sat, vecs[v].exp_ovf);
            handshake($sformatf("vec%0d", v));
        end

        // Idle gaps mid-pixel: accumulator holds.
        send_term(10'd100, 1'b0, 1'b0);
        tick();
        tick();
        check("gap_no_out_valid", bus.out_valid, 0);
        send_term(10'd30, 1'b0, 1'b1);
        check_out("gap", 8'd130, 1'b0, 1'b0);
        handshake("gap");

        // Force-close at MAX_TERMS; a fifth term waits for the handshake.
        for (int i = 0; i < 4; i++) send_term(10'd10, 1'b0, 1'b0);
        check_out("ovf5", 8'd40, 1'b0, 1'b1);
        bus.term_in   = 10'd10;
        bus.term_sub  = 1'b0;
        bus.term_last = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ovf5_hold_in_ready", bus.in_ready, 0);
            check("ovf5_hold_color", bus.color_out, 40);
            check("ovf5_single_pulse", bus.term_ovf, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("ovf5_idle_out_valid", bus.out_valid, 0);
        check("ovf5_idle_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid  = 1'b0;
        bus.term_last = 1'b0;
        check_out("ovf5_fifth", 8'd10, 1'b0, 1'b0);
        handshake("ovf5_fifth");

        // Backpressure: five cycles without out_ready.
        send_term(10'd5, 1'b0, 1'b0);
        send_term(10'd6, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_color", bus.color_out, 11);
            check("hold_sat", bus.sat_flag, 0);
            check("hold_in_ready", bus.in_ready, 0);
            tick();
        end
        handshake("hold");

        // Reset mid-pixel discards the partial sum and clears outputs.
        send_term(10'd50, 1'b0, 1'b0);
        send_term(10'd60, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_out_valid", bus.out_valid, 0);
        check("rstmid_color", bus.color_out, 0);
        check("rstmid_sat", bus.sat_flag, 0);
        check("rstmid_ovf", bus.term_ovf, 0);
        check("rstmid_in_ready", bus.in_ready, 1);
        tick();
        check("rstmid_still_idle", bus.out_valid, 0);
        send_term(10'd7, 1'b0, 1'b1);
        check_out("rstmid_next", 8'd7, 1'b0, 1'b0);
        handshake("rstmid_next");

        // Reset while a result is pending in OUT.
        send_term(10'd200, 1'b0, 1'b1);
        check_out("rstout_pre", 8'd200, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstout_out_valid", bus.out_valid, 0);
        check("rstout_color", bus.color_out, 0);
        check("rstout_in_ready", bus.in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
